// File: rtl/vga_stream_gen.sv
// ============================================================================
// Module      : vga_stream_gen
// Description : VGA timing plus pixel source (camera passthrough or a bouncing
//               green ball) with the ball's ground-truth grid cell.
//               Optional background grid lines: `define VGA_GRID_LINES_EN
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_stream_gen #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int BALL_SIZE  = 16,
  parameter int BLOCK_SIZE = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        PATTERN,
  input  logic [3:0]  STEP,
  input  logic [7:0]  CAM_R,
  input  logic [7:0]  CAM_G,
  input  logic [7:0]  CAM_B,
  output logic [12:0] VGA_H_CNT,
  output logic [12:0] VGA_V_CNT,
  output logic        HSYNC_N,
  output logic        VSYNC_N,
  output logic        BLANK,
  output logic        FRAME_START,
  output logic [7:0]  R_OUT,
  output logic [7:0]  G_OUT,
  output logic [7:0]  B_OUT,
  output logic [5:0]  BALL_X_REF,
  output logic [5:0]  BALL_Y_REF
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [12:0] H_LAST  = 13'(H_TOTAL - 1);
  localparam logic [12:0] V_LAST  = 13'(V_TOTAL - 1);
  localparam logic [12:0] HS_END  = 13'(H_SYNC);
  localparam logic [12:0] VS_END  = 13'(V_SYNC);
  localparam logic [12:0] X_START = 13'(H_SYNC + H_BP);
  localparam logic [12:0] X_END   = 13'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [12:0] Y_START = 13'(V_SYNC + V_BP);
  localparam logic [12:0] Y_END   = 13'(V_SYNC + V_BP + V_ACTIVE);
  localparam logic [12:0] BSIZE13 = 13'(BALL_SIZE);
  localparam logic [10:0] X_LIM   = 11'(H_ACTIVE - BALL_SIZE);
  localparam logic [10:0] Y_LIM   = 11'(V_ACTIVE - BALL_SIZE);
  localparam logic [10:0] HALF    = 11'(BALL_SIZE / 2);
  localparam logic [10:0] BLK11   = 11'(BLOCK_SIZE);

  logic        run_q;
  logic [12:0] h_q, v_q, h_d, v_d;
  logic        hs_q, vs_q, blank_q, fs_q;
  logic        hs_d, vs_d, blank_d, fs_d;
  logic [7:0]  r_q, g_q, b_q, r_d, g_d, b_d;
  logic        mode_q;
  logic [10:0] bx_q, by_q, bx_d, by_d;
  logic        dx_q, dy_q, dx_d, dy_d;
  logic [5:0]  xref_q, yref_q, xref_d, yref_d;

  logic [12:0] x_d, y_d, bx_ext, by_ext;
  logic        in_ball, on_grid;
  logic [10:0] step11, nx, ny;

  // run_q holds the counters at 0 for the first cycle after reset release so
  // that cycle presents H=0,V=0 with FRAME_START.
  always_comb begin
    h_d = '0;
    v_d = '0;
    if (run_q) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? 13'd0 : v_q + 13'd1;
      end else begin
        h_d = h_q + 13'd1;
        v_d = v_q;
      end
    end
  end

  always_comb begin
    hs_d    = !(h_d < HS_END);
    vs_d    = !(v_d < VS_END);
    blank_d = !((h_d >= X_START) && (h_d < X_END) &&
                (v_d >= Y_START) && (v_d < Y_END));
    fs_d    = (h_d == 13'd0) && (v_d == 13'd0);
  end

  always_comb begin
    x_d     = h_d - X_START;
    y_d     = v_d - Y_START;
    bx_ext  = {2'b00, bx_q};
    by_ext  = {2'b00, by_q};
    in_ball = (x_d >= bx_ext) && (x_d < bx_ext + BSIZE13) &&
              (y_d >= by_ext) && (y_d < by_ext + BSIZE13);
`ifdef VGA_GRID_LINES_EN
    on_grid = ((x_d % 13'(BLOCK_SIZE)) == 13'd0) ||
              ((y_d % 13'(BLOCK_SIZE)) == 13'd0);
`else
    on_grid = 1'b0;
`endif
    r_d = 8'd0;
    g_d = 8'd0;
    b_d = 8'd0;
    if (!blank_d) begin
      if (!mode_q) begin
        r_d = CAM_R;
        g_d = CAM_G;
        b_d = CAM_B;
      end else if (in_ball) begin
        g_d = 8'd255;
      end else if (on_grid) begin
        r_d = 8'd128;
        g_d = 8'd128;
        b_d = 8'd128;
      end else begin
        r_d = 8'd32;
        g_d = 8'd32;
        b_d = 8'd32;
      end
    end
  end

  // Per-frame ball step; STEP=0 freezes both position and direction.
  always_comb begin
    bx_d   = bx_q;
    by_d   = by_q;
    dx_d   = dx_q;
    dy_d   = dy_q;
    step11 = {7'd0, STEP};
    nx     = bx_q + step11;
    ny     = by_q + step11;
    if (STEP != 4'd0) begin
      if (!dx_q) begin
        if (nx >= X_LIM) begin
          bx_d = X_LIM;
          dx_d = 1'b1;
        end else begin
          bx_d = nx;
        end
      end else if (bx_q <= step11) begin
        bx_d = '0;
        dx_d = 1'b0;
      end else begin
        bx_d = bx_q - step11;
      end
      if (!dy_q) begin
        if (ny >= Y_LIM) begin
          by_d = Y_LIM;
          dy_d = 1'b1;
        end else begin
          by_d = ny;
        end
      end else if (by_q <= step11) begin
        by_d = '0;
        dy_d = 1'b0;
      end else begin
        by_d = by_q - step11;
      end
    end
    xref_d = 6'((bx_d + HALF) / BLK11);
    yref_d = 6'((by_d + HALF) / BLK11);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      run_q   <= 1'b0;
      h_q     <= '0;
      v_q     <= '0;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      blank_q <= 1'b1;
      fs_q    <= 1'b0;
      r_q     <= '0;
      g_q     <= '0;
      b_q     <= '0;
      mode_q  <= 1'b0;
      bx_q    <= '0;
      by_q    <= '0;
      dx_q    <= 1'b0;
      dy_q    <= 1'b0;
      xref_q  <= '0;
      yref_q  <= '0;
    end else begin
      run_q   <= 1'b1;
      h_q     <= h_d;
      v_q     <= v_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      blank_q <= blank_d;
      fs_q    <= fs_d;
      r_q     <= r_d;
      g_q     <= g_d;
      b_q     <= b_d;
      if (fs_q) begin
        mode_q <= PATTERN;
        bx_q   <= bx_d;
        by_q   <= by_d;
        dx_q   <= dx_d;
        dy_q   <= dy_d;
        xref_q <= xref_d;
        yref_q <= yref_d;
      end
    end
  end

  assign VGA_H_CNT   = h_q;
  assign VGA_V_CNT   = v_q;
  assign HSYNC_N     = hs_q;
  assign VSYNC_N     = vs_q;
  assign BLANK       = blank_q;
  assign FRAME_START = fs_q;
  assign R_OUT       = r_q;
  assign G_OUT       = g_q;
  assign B_OUT       = b_q;
  assign BALL_X_REF  = xref_q;
  assign BALL_Y_REF  = yref_q;

endmodule

`default_nettype wire

// File: doc/vga_stream_gen.md
Name: vga_stream_gen

Overview:
- Produces the VGA pixel stream that the green-ball detector and overlay stages consume: 13-bit H/V counters, active-low syncs, blank, and 8-bit RGB.
- RGB comes from either the camera passthrough or a synthetic test pattern. The test pattern is a bouncing pure-green square, used for bench checking of the ball-detection path.
- Also exports the ground-truth 16x16 grid cell of the synthetic ball, for direct comparison with the detector's BALL_X/BALL_Y.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch
H_SYNC, 96, hsync width
H_BP, 48, horizontal back porch
V_ACTIVE, 480, visible lines
V_FP, 10, vertical front porch
V_SYNC, 2, vsync width
V_BP, 33, vertical back porch
BALL_SIZE, 16, synthetic ball edge length in pixels
BLOCK_SIZE, 16, grid cell size used for BALL_X_REF/BALL_Y_REF

Ports:
CLK  input  1  pixel clock
RST  input  1  synchronous, active-high reset
PATTERN  input  1  0 = camera passthrough, 1 = synthetic ball
STEP  input  4  ball movement in pixels per frame, applied on both axes
CAM_R / CAM_G / CAM_B  input  8 each  camera pixel, aligned to the current counters
VGA_H_CNT  output  13  horizontal count
VGA_V_CNT  output  13  vertical count
HSYNC_N  output  1  active-low hsync
VSYNC_N  output  1  active-low vsync
BLANK  output  1  1 outside the active area
FRAME_START  output  1  one-cycle pulse, high while H=0 and V=0
R_OUT / G_OUT / B_OUT  output  8 each  pixel data
BALL_X_REF / BALL_Y_REF  output  6 each  grid cell of the ball centre

Behaviour:
- Derived values:
  - H_TOTAL = sum of the H parameters (800); V_TOTAL = sum of the V parameters (525).
  - X_START = H_SYNC + H_BP (144); Y_START = V_SYNC + V_BP (35).
- Counters:
  - H_CNT increments every cycle and wraps from H_TOTAL-1 to 0.
  - V_CNT increments on each H wrap and wraps from V_TOTAL-1 to 0.
- Sync and blank decode:
  - HSYNC_N = 0 iff H_CNT < H_SYNC.
  - VSYNC_N = 0 iff V_CNT < V_SYNC.
  - BLANK = 0 iff X_START <= H_CNT < X_START+H_ACTIVE and Y_START <= V_CNT < Y_START+V_ACTIVE.
- Output alignment:
  - All outputs are registered.
  - Sync, BLANK, FRAME_START and RGB presented in a cycle describe the VGA_H_CNT/VGA_V_CNT presented in that same cycle. This means they are decoded from next-count values.
- Reset (RST high at a clock edge), all taking effect next cycle, including mid-frame:
  - Counters = 0, HSYNC_N = VSYNC_N = 1, BLANK = 1, FRAME_START = 0, RGB = 0.
  - Ball position = (0,0), direction = +x,+y, mode register = 0, BALL_X_REF = BALL_Y_REF = 0.
  - First cycle after release presents H=0, V=0 with FRAME_START = 1.
- Mode register:
  - Loaded from PATTERN only on the FRAME_START cycle.
  - Toggling PATTERN mid-frame has no effect until the next frame.
- Pixel source:
  - BLANK = 1: RGB = 0.
  - Mode 0: RGB = CAM_R/G/B.
  - Mode 1: with x = H_CNT-X_START and y = V_CNT-Y_START, the pixel is inside the ball when BX <= x < BX+BALL_SIZE and BY <= y < BY+BALL_SIZE.
    - Inside the ball: RGB = (0,255,0).
    - Otherwise: RGB = (32,32,32).
- Ball motion:
  - Updated once per frame, on the FRAME_START cycle.
  - Updates occur in both modes, so position is continuous across mode switches.
  - X update, moving +x: nx = BX+STEP. If nx >= H_ACTIVE-BALL_SIZE, then BX = H_ACTIVE-BALL_SIZE (624) and direction flips; else BX = nx.
  - X update, moving -x: if BX <= STEP, then BX = 0 and direction flips; else BX = BX-STEP.
  - Y axis is identical, with limit V_ACTIVE-BALL_SIZE (464).
  - STEP = 0: ball is stationary and directions do not change.
  - Arithmetic is 11-bit unsigned; no underflow is permitted.
- Reference outputs:
  - BALL_X_REF = (BX + BALL_SIZE/2) / BLOCK_SIZE; BALL_Y_REF is the same using BY.
  - Registered in the same cycle as the position update, so they are stable for the whole frame.

Optional Feature:
- Macro: VGA_GRID_LINES_EN.
- Defined: in mode 1, a non-ball active pixel with x % BLOCK_SIZE == 0 or y % BLOCK_SIZE == 0 outputs (128,128,128). This visualises detector cells; the grey is achromatic, so it is never classified green.
- Undefined: the background is uniformly (32,32,32).
- Mode 0 is identical either way.

Test Plan:
1. Reset, timing start: hold RST for 3 cycles, then release.
   - Required: H_CNT runs 0,1,2…; after H=799 it returns to 0 and V_CNT becomes 1.
   - Required: HSYNC_N is low exactly for H = 0..95; FRAME_START is high only on the first cycle.
2. Full frame: run 2×420000 cycles.
   - Required: FRAME_START pulses exactly every 420000 cycles.
   - Required: VSYNC_N is low for V = 0..1 (1600 cycles); BLANK is low for exactly 307200 cycles per frame; RGB = 0 whenever BLANK = 1.
3. Pattern and motion: PATTERN=1, STEP=4.
   - Frame 1: pixels (H=144..159, V=35..50) = (0,255,0), pixel (H=160, V=35) = (32,32,32).
   - Frame 2: ball at (4,4), BALL_X_REF = 0. Frame 4: ball at (12,12), BALL_X_REF = BALL_Y_REF = 1.
4. Bounce: STEP=15, run to the wall.
   - Required: BX sequence reaches 615, then 624 clamp with direction flip, then 609.
   - Required: BY clamps at 464 and reverses; BALL_X_REF = 39 at BX=624.
5. Mode change mid-frame: assert PATTERN at V=200 while in mode 0.
   - Required: camera data continues to the end of the frame; the pattern appears starting at the next FRAME_START.
6. Reset mid-frame: assert RST at H=400, V=300 with the ball at (100,80).
   - Required: next cycle has counters = 0, RGB = 0, syncs = 1; after release the ball is at (0,0) and FRAME_START = 1.
